spi_slave_regs: RTL

SPI mode-0 slave with a 4-entry byte register file, the downstream peer of `spi_master`. It consumes the master's `cs`, `sclk` and `mosi`, drives `miso` back, and exposes its registers to local logic. All SPI inputs are oversampled in the `clk` domain: no logic is clocked by `sclk`. The block serves as the on-chip target for `spi_master` bring-up and as a register port for downstream logic.

---
 rtl/spi_slave_regs_if.sv | 17 +
 rtl/spi_slave_regs.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regs_if
// Description : SPI mode-0 bus bundle (cs, sclk, mosi, miso) between an SPI
//               master and the spi_slave_regs target.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_regs_if;
   logic cs;
   logic sclk;
   logic mosi;
   logic miso;

   modport master (output cs, output sclk, output mosi, input miso);
   modport slave  (input cs, input sclk, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/spi_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regs
// Description : SPI mode-0 slave with a 4-entry byte register file. All SPI
//               inputs are oversampled in the clk domain. Register 0 is a
//               read-only ID; registers 1-3 are read/write.
//               Build option: define SPI_SLAVE_AUTOINC_EN to advance the
//               address (wrapping 3->0) after every data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regs #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] ID_VALUE    = 8'hA5
) (
   input  logic            clk,
   input  logic            rst,
   spi_slave_regs_if.slave spi,
   output logic [7:0]      reg1_q,
   output logic [7:0]      reg2_q,
   output logic [7:0]      reg3_q,
   output logic            wr_strobe,
   output logic [1:0]      wr_addr,
   output logic            busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Input synchronisers and edge detection
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_cs_q;
   logic                   r_sclk_q;
   logic                   r_armed;
   logic                   r_sclk_rise;
   logic                   r_sclk_fall;
   logic                   r_cs_fall;
   logic                   r_cs_rise;
   logic                   r_mosi_d;
   logic                   r_busy;
   logic                   w_cs_s;
   logic                   w_sclk_s;
   logic                   w_mosi_s;

   // Protocol state and register file
   state_t     r_state;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift_in;
   logic [7:0] r_shift_out;
   logic       r_is_read;
   logic [1:0] r_addr;
   logic       r_miso;
   logic [7:0] r_reg1;
   logic [7:0] r_reg2;
   logic [7:0] r_reg3;
   logic       r_wr_strobe;
   logic [1:0] r_wr_addr;
   logic [7:0] w_byte;
   logic [7:0] w_rd_val;
   logic [1:0] w_next_addr;

   assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

   // Byte as it stands once the current mosi bit is shifted in
   assign w_byte = {r_shift_in, r_mosi_d};

`ifdef SPI_SLAVE_AUTOINC_EN
   assign w_next_addr = r_addr + 2'd1;
`else
   assign w_next_addr = r_addr;
`endif

   // Read mux: register 0 is the fixed ID value
   always_comb begin
      w_rd_val = ID_VALUE;
      case (r_addr)
         2'd1:    w_rd_val = r_reg1;
         2'd2:    w_rd_val = r_reg2;
         2'd3:    w_rd_val = r_reg3;
         default: w_rd_val = ID_VALUE;
      endcase
   end

   // Synchronise SPI inputs and produce registered edge pulses with aligned mosi.
   // Chains reset to 0 and a cs fall needs a previously seen high cs, so a reset
   // taken mid-transaction cannot fake a new cs_fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_sync   <= '0;
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_cs_q      <= 1'b0;
         r_sclk_q    <= 1'b0;
         r_armed     <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_sclk_fall <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_mosi_d    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
         r_cs_q      <= w_cs_s;
         r_sclk_q    <= w_sclk_s;
         r_armed     <= r_armed | w_cs_s;
         r_sclk_rise <= w_sclk_s & ~r_sclk_q;
         r_sclk_fall <= ~w_sclk_s & r_sclk_q;
         r_cs_fall   <= r_cs_q & ~w_cs_s;
         r_cs_rise   <= ~r_cs_q & w_cs_s;
         r_mosi_d    <= w_mosi_s;
         r_busy      <= r_armed & ~w_cs_s;
      end
   end

   // Command/data FSM, register writes, strobe generation and miso shifting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift_in  <= 7'd0;
         r_shift_out <= 8'd0;
         r_is_read   <= 1'b0;
         r_addr      <= 2'd0;
         r_miso      <= 1'b0;
         r_reg1      <= 8'd0;
         r_reg2      <= 8'd0;
         r_reg3      <= 8'd0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= 2'd0;
      end else begin
         r_wr_strobe <= 1'b0;
         if (r_cs_rise) begin
            // Any partial byte is dropped; committed bytes stay committed
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_miso    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (r_cs_fall) begin
                     r_state   <= ST_CMD;
                     r_bit_cnt <= 3'd0;
                     r_miso    <= 1'b0;
                  end
               end
               ST_CMD: begin
                  if (r_sclk_rise) begin
                     r_shift_in <= w_byte[6:0];
                     r_bit_cnt  <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_is_read <= w_byte[7];
                        r_addr    <= w_byte[1:0];
                        r_state   <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (r_sclk_rise) begin
                     r_shift_in <= w_byte[6:0];
                     r_bit_cnt  <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        if (!r_is_read && r_addr != 2'd0) begin
                           r_wr_strobe <= 1'b1;
                           r_wr_addr   <= r_addr;
                           case (r_addr)
                              2'd1:    r_reg1 <= w_byte;
                              2'd2:    r_reg2 <= w_byte;
                              default: r_reg3 <= w_byte;
                           endcase
                        end
                        r_addr <= w_next_addr;
                     end
                  end else if (r_sclk_fall && r_is_read) begin
                     // Byte boundary: capture the register so later local writes
                     // cannot disturb the byte being shifted out
                     if (r_bit_cnt == 3'd0) begin
                        r_miso      <= w_rd_val[7];
                        r_shift_out <= {w_rd_val[6:0], 1'b0};
                     end else begin
                        r_miso      <= r_shift_out[7];
                        r_shift_out <= {r_shift_out[6:0], 1'b0};
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_miso  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign spi.miso  = r_miso;
   assign reg1_q    = r_reg1;
   assign reg2_q    = r_reg2;
   assign reg3_q    = r_reg3;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign busy      = r_busy;

endmodule
`default_nettype wire
